// File: rtl/modinv_binary_if.sv
// Request/response bundle for the binary modular-inverse engine.
// Handshake: start is sampled only while busy = 0 and done = 0; done pulses for one cycle with inv/valid updated.
interface modinv_binary_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] m;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] inv;
    logic [1:0]       state_dbg;

    modport master (
        output start, a, m,
        input  busy, done, valid, inv, state_dbg
    );

    modport slave (
        input  start, a, m,
        output busy, done, valid, inv, state_dbg
    );
endinterface

// File: rtl/modinv_binary.sv
// Binary extended-Euclid modular inverse: inv = a^-1 mod m for odd m.
// One shift or subtract step per clock; Bezout coefficients x1/x2 are kept in [0, m-1].
module modinv_binary #(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    modinv_binary_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOOP = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] x1;
    logic [WIDTH-1:0] x2;
    logic [WIDTH-1:0] res;
    logic             res_ok;
    logic             done_r;
    logic             valid_r;
    logic [WIDTH-1:0] inv_r;
    logic             accept;
    logic             illegal;

    // Halving mod an odd modulus: an odd x becomes even after adding m.
    function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] md);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    // p - q mod md for p, q already reduced; wrap-around arithmetic is exact here.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] p,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] md);
        return (p >= q) ? (p - q) : (p - q + md);
    endfunction

    // The done cycle is still treated as the tail of the previous operation.
    assign accept  = (state == IDLE) && bus.start && !done_r;
    assign illegal = !bus.m[0] || (bus.m < WIDTH'(3)) ||
                     (bus.a == '0) || (bus.a >= bus.m);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            m_r     <= '0;
            u       <= '0;
            v       <= '0;
            x1      <= '0;
            x2      <= '0;
            res     <= '0;
            res_ok  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            inv_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_r    <= bus.m;
                        u      <= bus.a;
                        v      <= bus.m;
                        x1     <= WIDTH'(1);
                        x2     <= '0;
                        res    <= '0;
                        res_ok <= 1'b0;
                        state  <= illegal ? FIN : LOOP;
                    end
                end
                LOOP: begin
                    if (u == WIDTH'(1)) begin
                        res    <= x1;
                        res_ok <= 1'b1;
                        state  <= FIN;
                    end else if (v == WIDTH'(1)) begin
                        res    <= x2;
                        res_ok <= 1'b1;
                        state  <= FIN;
                    end else if ((u == '0) || (v == '0)) begin
                        res_ok <= 1'b0;
                        state  <= FIN;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= halve_mod(x1, m_r);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= halve_mod(x2, m_r);
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= sub_mod(x1, x2, m_r);
                    end else begin
                        v  <= v - u;
                        x2 <= sub_mod(x2, x1, m_r);
                    end
                end
                FIN: begin
                    done_r  <= 1'b1;
                    valid_r <= res_ok;
                    inv_r   <= res_ok ? res : '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_r;
    assign bus.valid     = valid_r;
    assign bus.inv       = inv_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_modinv_binary.sv
// Bench for modinv_binary: directed WIDTH=4 cases plus randomized WIDTH=16 against an extended-Euclid model.
module tb_modinv_binary;

  localparam int W4   = 4;
  localparam int W16  = 16;
  localparam int LIM4  = 4 * W4 + 6;
  localparam int LIM16 = 4 * W16 + 6;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [W16:0] exp_q[$];

  modinv_binary_if #(.WIDTH(W4))  if4 ();
  modinv_binary_if #(.WIDTH(W16)) if16 ();

  modinv_binary #(.WIDTH(W4))  dut4  (.clk(clk), .reset(reset), .bus(if4));
  modinv_binary #(.WIDTH(W16)) dut16 (.clk(clk), .reset(reset), .bus(if16));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: division-based extended Euclid on plain integers.
  function automatic void ref_inv(input longint a, input longint m,
                                  output bit ok, output longint inv);
    longint r0, r1, s0, s1, q, t;
    ok = 1'b0;
    inv = 0;
    if ((m % 2 == 0) || (m < 3) || (a == 0) || (a >= m)) return;
    r0 = a; r1 = m; s0 = 1; s1 = 0;
    while (r1 != 0) begin
      q = r0 / r1;
      t = r0 - q * r1; r0 = r1; r1 = t;
      t = s0 - q * s1; s0 = s1; s1 = t;
    end
    if (r0 == 1) begin
      ok = 1'b1;
      inv = ((s0 % m) + m) % m;
    end
  endfunction

  // n = edges after the start edge until done is seen, i.e. LOOP cycles + 1.
  task automatic wait_done4(output int n);
    n = 0;
    while (!if4.done && n < LIM4) begin
      @(posedge clk); #1;
      n++;
    end
    if (!if4.done) check("timeout4", 0, 1);
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (!if16.done && n < LIM16) begin
      @(posedge clk); #1;
      n++;
    end
    if (!if16.done) check("timeout16", 0, 1);
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] m,
                     input logic ev, input logic [3:0] einv, input int en);
    int n;
    @(negedge clk);
    if4.start = 1'b1; if4.a = a; if4.m = m;
    @(posedge clk); #1;
    if4.start = 1'b0;
    check({tag, "_busy"}, if4.busy, 1);
    wait_done4(n);
    check({tag, "_valid"}, if4.valid, ev);
    check({tag, "_inv"}, if4.inv, einv);
    check({tag, "_busy_at_done"}, if4.busy, 0);
    check({tag, "_bound"}, ((n - 1) <= 4 * W4 + 1), 1);
    if (en >= 0) check({tag, "_loops"}, n - 1, en);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, if4.done, 0);
    check({tag, "_inv_hold"}, if4.inv, einv);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] m);
    bit     ok;
    longint ri;
    int     n;
    logic [W16:0] got, exp;
    ref_inv(longint'(a), longint'(m), ok, ri);
    exp_q.push_back({ok, ri[15:0]});
    @(negedge clk);
    if16.start = 1'b1; if16.a = a; if16.m = m;
    @(posedge clk); #1;
    if16.start = 1'b0;
    wait_done16(n);
    got = {if16.valid, if16.inv};
    exp = exp_q.pop_front();
    check("rand_result", got, exp);
    check("rand_bound", ((n - 1) <= 4 * W16 + 1), 1);
    if (if16.valid) begin
      check("rand_identity", (longint'(a) * longint'(if16.inv)) % longint'(m), 1);
      check("rand_range", (if16.inv < m), 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int pulses;
    logic [15:0] rm, ra;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.m = '0;
    if16.start = 1'b0; if16.a = '0; if16.m = '0;
    #1;
    check("rst_busy", if4.busy, 0);
    check("rst_done", if4.done, 0);
    check("rst_valid", if4.valid, 0);
    check("rst_inv", if4.inv, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // directed cases
    op4("inv3_7",   4'd3,  4'd7,  1'b1, 4'd5, 4);
    op4("inv4_15",  4'd4,  4'd15, 1'b1, 4'd4, -1);
    op4("gcd3",     4'd12, 4'd15, 1'b0, 4'd0, -1);
    op4("inv1_15",  4'd1,  4'd15, 1'b1, 4'd1, 1);
    op4("m_even",   4'd3,  4'd14, 1'b0, 4'd0, 0);
    op4("a_zero",   4'd0,  4'd7,  1'b0, 4'd0, 0);
    op4("a_ge_m",   4'd9,  4'd7,  1'b0, 4'd0, 0);
    op4("inv2_3",   4'd2,  4'd3,  1'b1, 4'd2, -1);

    // start while busy is ignored
    @(negedge clk);
    if4.start = 1'b1; if4.a = 4'd3; if4.m = 4'd7;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(negedge clk);
    if4.start = 1'b1; if4.a = 4'd4; if4.m = 4'd15;
    @(posedge clk); #1;
    if4.start = 1'b0;
    wait_done4(n);
    check("busy_start_valid", if4.valid, 1);
    check("busy_start_inv", if4.inv, 5);

    // start in the done cycle is rejected, next cycle accepted
    if4.start = 1'b1; if4.a = 4'd1; if4.m = 4'd15;
    @(posedge clk); #1;
    check("done_cycle_reject", if4.busy, 0);
    @(posedge clk); #1;
    if4.start = 1'b0;
    check("next_cycle_accept", if4.busy, 1);
    wait_done4(n);
    check("next_cycle_valid", if4.valid, 1);
    check("next_cycle_inv", if4.inv, 1);
    check("next_cycle_loops", n - 1, 1);
    @(posedge clk); #1;

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    if4.start = 1'b1; if4.a = 4'd3; if4.m = 4'd7;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", if4.busy, 0);
    check("midrst_done", if4.done, 0);
    check("midrst_valid", if4.valid, 0);
    check("midrst_inv", if4.inv, 0);
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if4.done) pulses++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (if4.done) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    op4("after_rst", 4'd5, 4'd7, 1'b1, 4'd3, -1);

    // randomized WIDTH=16
    for (int i = 0; i < 40; i++) begin
      rm = 16'($urandom_range(3, 65535)) | 16'd1;
      if (i % 4 == 0) begin
        ra = 16'((longint'($urandom_range(1, 200)) * 3) % longint'(rm));
        if (ra == 16'd0) ra = 16'd1;
      end else begin
        ra = 16'($urandom_range(1, int'(rm) - 1));
      end
      op16(ra, rm);
    end
    op16(16'd1, 16'd65535);
    op16(16'd65534, 16'd65535);
    op16(16'd3, 16'd65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
